// File: rtl/core_mc_ctrl.sv
// core_mc_ctrl: multi-cycle RV32I control FSM sequencing fetch/decode/exec/mem/wb over one memory port.
// Optional performance counters are compiled in when CORE_MC_CTRL_PERF_EN is defined.
module core_mc_ctrl #(
    parameter int BUS_TIMEOUT   = 0,
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ir_opcode,
    input  logic [1:0]  ir_lo,
    input  logic        branch_taken,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic        retire,
`ifdef CORE_MC_CTRL_PERF_EN
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_instret,
`endif
    output logic [3:0]  dbg_state
);
    // Memory handshake: mem_req stays high until a cycle in which mem_gnt is also high; that cycle
    // transfers the request. Read data for an accepted read returns on mem_rvalid in a later cycle.

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_MWAIT  = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OPIMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

    localparam int HW = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;
    localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((RESET_PC_HOLD > 1) ? RESET_PC_HOLD - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST  = TW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);
    localparam logic          TMO_EN    = (BUS_TIMEOUT > 0);

    state_e          state_q, state_d;
    logic [4:0]      opc_q, opc_d;
    logic            br_q, br_d;
    logic [1:0]      cause_q, cause_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            tmo_expired;
    logic [TW-1:0]   tmo_next;
    logic            ir_legal;

    assign tmo_expired = TMO_EN && (tmo_q == TMO_LAST);
    assign tmo_next    = TMO_EN ? tmo_q + 1'b1 : '0;

    always_comb begin
        ir_legal = 1'b0;
        case (ir_opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OPIMM, OPC_AUIPC, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: ir_legal = 1'b1;
            default:                                         ir_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            opc_q   <= '0;
            br_q    <= 1'b0;
            cause_q <= '0;
            hold_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            br_q    <= br_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    // Timeout counter only advances while staying in a wait state, so any transition clears it.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        br_d    = br_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        tmo_d   = '0;
        case (state_q)
            S_RESET: begin
                if (hold_q == HOLD_LAST) state_d = S_FETCH;
                else                     hold_d  = hold_q + 1'b1;
            end
            S_FETCH: begin
                if (mem_gnt) begin
                    state_d = S_FWAIT;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BUS;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            S_FWAIT: begin
                if (mem_rvalid) begin
                    state_d = S_DECODE;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BUS;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            S_DECODE: begin
                opc_d = ir_opcode;
                if (ir_lo != 2'b11 || !ir_legal) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_ILLEGAL;
                end else if (ir_opcode == OPC_MISC_MEM) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                br_d = branch_taken;
                if (opc_q == OPC_LOAD || opc_q == OPC_STORE) state_d = S_MEM;
                else                                         state_d = S_WB;
            end
            S_MEM: begin
                if (mem_gnt) begin
                    state_d = (opc_q == OPC_STORE) ? S_WB : S_MWAIT;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BUS;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            S_MWAIT: begin
                if (mem_rvalid) begin
                    state_d = S_WB;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BUS;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Selects depend on the latched opcode only, never on the live IR.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        halted       = 1'b0;
        halt_cause   = 2'd0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: mem_req = 1'b1;
            S_FWAIT: ir_we   = mem_rvalid;
            S_EXEC: begin
                case (opc_q)
                    OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR: alu_b_sel = 1'b1;
                    OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opc_q == OPC_STORE);
            end
            S_MWAIT: wb_sel = 2'd1;
            S_WB: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                rf_we  = !(opc_q == OPC_STORE || opc_q == OPC_BRANCH || opc_q == OPC_MISC_MEM);
                case (opc_q)
                    OPC_LUI:           wb_sel = 2'd3;
                    OPC_JAL, OPC_JALR: wb_sel = 2'd2;
                    OPC_LOAD:          wb_sel = 2'd1;
                    default:           wb_sel = 2'd0;
                endcase
                if (opc_q == OPC_JAL || opc_q == OPC_JALR || (opc_q == OPC_BRANCH && br_q))
                    pc_sel = 2'd1;
            end
            S_HALT: begin
                halted     = 1'b1;
                halt_cause = cause_q;
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;

`ifdef CORE_MC_CTRL_PERF_EN
    logic [63:0] perf_cycles_q, perf_instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            if (state_q != S_RESET && state_q != S_HALT) perf_cycles_q <= perf_cycles_q + 64'd1;
            if (state_q == S_WB)                         perf_instret_q <= perf_instret_q + 64'd1;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_core_mc_ctrl.sv
// tb_core_mc_ctrl: self-checking bench for core_mc_ctrl; WB signatures are queued per instruction
// and checked by a retire monitor, state/handshake behaviour is checked inline per cycle.
module tb_core_mc_ctrl;
  localparam int BUS_TIMEOUT   = 8;
  localparam int RESET_PC_HOLD = 1;

  localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_FWAIT = 4'd2, S_DECODE = 4'd3,
                         S_EXEC = 4'd4, S_MEM = 4'd5, S_MWAIT = 4'd6, S_WB = 4'd7, S_HALT = 4'd8;

  localparam logic [4:0] OPC_LOAD = 5'b00000, OPC_MISC = 5'b00011, OPC_OPIMM = 5'b00100,
                         OPC_AUIPC = 5'b00101, OPC_STORE = 5'b01000, OPC_OP = 5'b01100,
                         OPC_LUI = 5'b01101, OPC_BRANCH = 5'b11000, OPC_JALR = 5'b11001,
                         OPC_JAL = 5'b11011;

  logic       clk, rst_n;
  logic [4:0] ir_opcode;
  logic [1:0] ir_lo;
  logic       branch_taken, mem_gnt, mem_rvalid;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0] pc_sel;
  logic       alu_a_sel, alu_b_sel, rf_we;
  logic [1:0] wb_sel;
  logic       halted;
  logic [1:0] halt_cause;
  logic       retire;
  logic [3:0] dbg_state;
`ifdef CORE_MC_CTRL_PERF_EN
  logic [63:0] perf_cycles, perf_instret;
`endif

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_got, mon_exp;
  logic [4:0] legal_ops [10] = '{OPC_LOAD, OPC_MISC, OPC_OPIMM, OPC_AUIPC, OPC_STORE,
                                 OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};

  core_mc_ctrl #(.BUS_TIMEOUT(BUS_TIMEOUT), .RESET_PC_HOLD(RESET_PC_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ir_lo(ir_lo),
    .branch_taken(branch_taken), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted), .halt_cause(halt_cause),
    .retire(retire),
`ifdef CORE_MC_CTRL_PERF_EN
    .perf_cycles(perf_cycles), .perf_instret(perf_instret),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected WB signature {rf_we, wb_sel, pc_sel, pc_we}
  function automatic logic [5:0] exp_sig(input logic [4:0] opc, input logic taken);
    logic       rf;
    logic [1:0] wb, ps;
    rf = !(opc == OPC_STORE || opc == OPC_BRANCH || opc == OPC_MISC);
    wb = (opc == OPC_LUI) ? 2'd3 : (opc == OPC_JAL || opc == OPC_JALR) ? 2'd2 :
         (opc == OPC_LOAD) ? 2'd1 : 2'd0;
    ps = (opc == OPC_JAL || opc == OPC_JALR || (opc == OPC_BRANCH && taken)) ? 2'd1 : 2'd0;
    return {rf, wb, ps, 1'b1};
  endfunction

  function automatic logic is_legal(input logic [4:0] opc);
    for (int i = 0; i < 10; i++) if (legal_ops[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  // retire monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && retire === 1'b1) begin
      mon_got = {rf_we, wb_sel, pc_sel, pc_we};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected: got sig=%h, none expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL wb_sig: got {rf_we,wb_sel,pc_sel,pc_we}=%b want %b", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; branch_taken = 1'b0;
    ir_opcode = 5'd0; ir_lo = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (RESET_PC_HOLD) tick();
  endtask

  // Drives one instruction from FETCH to WB; expects to be entered in FETCH at posedge+1.
  task automatic run_instr(input logic [4:0] opc, input logic [1:0] lo, input logic taken,
                           input int gd, input int rd, input int gdm, input int rdm,
                           input string name);
    logic ill, ls, ld, st, ea, eb, chk_alu;
    int   cyc, exp_cyc;
    ill = (lo != 2'b11) || !is_legal(opc);
    ld  = (opc == OPC_LOAD);
    st  = (opc == OPC_STORE);
    ls  = ld || st;
    cyc = 0;
    exp_cyc = (gd + 1) + (rd + 1) + 1 + ((opc == OPC_MISC) ? 0 : 1) + (ls ? gdm + 1 : 0) +
              (ld ? rdm + 1 : 0) + 1;
    chk_alu = (opc != OPC_LUI);
    ea = (opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_BRANCH);
    eb = (opc != OPC_OP);
    if (!ill) exp_q.push_back(exp_sig(opc, taken));

    for (int k = 0; k <= gd; k++) begin
      mem_gnt = (k == gd);
      mem_rvalid = 1'b0;
      @(negedge clk);
      total++;
      if (dbg_state !== S_FETCH || mem_req !== 1'b1 || mem_addr_sel !== 1'b0 || mem_we !== 1'b0) begin
        bad++;
        $display("FAIL %s_fetch: state=%0d req=%b addr_sel=%b we=%b want state=%0d req=1 addr_sel=0 we=0",
                 name, dbg_state, mem_req, mem_addr_sel, mem_we, S_FETCH);
      end
      cyc++;
      tick();
    end
    mem_gnt = 1'b0;

    for (int k = 0; k <= rd; k++) begin
      mem_rvalid = (k == rd);
      if (k == rd) begin ir_opcode = opc; ir_lo = lo; end
      @(negedge clk);
      total++;
      if (dbg_state !== S_FWAIT || mem_req !== 1'b0 || ir_we !== (k == rd)) begin
        bad++;
        $display("FAIL %s_fwait: state=%0d req=%b ir_we=%b want state=%0d req=0 ir_we=%b",
                 name, dbg_state, mem_req, ir_we, S_FWAIT, (k == rd));
      end
      cyc++;
      tick();
    end
    mem_rvalid = 1'b0;

    @(negedge clk);
    total++;
    if (dbg_state !== S_DECODE || mem_req !== 1'b0 || rf_we !== 1'b0 || pc_we !== 1'b0) begin
      bad++;
      $display("FAIL %s_decode: state=%0d req=%b rf_we=%b pc_we=%b want state=%0d all 0",
               name, dbg_state, mem_req, rf_we, pc_we, S_DECODE);
    end
    cyc++;
    tick();
    ir_opcode = ~opc;
    ir_lo = 2'b00;

    if (ill) begin
      for (int k = 0; k < 4; k++) begin
        mem_gnt = k[0];
        @(negedge clk);
        total++;
        if (dbg_state !== S_HALT || halted !== 1'b1 || halt_cause !== 2'd1 || mem_req !== 1'b0) begin
          bad++;
          $display("FAIL %s_halt: state=%0d halted=%b cause=%0d req=%b want state=%0d halted=1 cause=1 req=0",
                   name, dbg_state, halted, halt_cause, mem_req, S_HALT);
        end
        tick();
      end
      mem_gnt = 1'b0;
      return;
    end

    if (opc != OPC_MISC) begin
      branch_taken = taken;
      @(negedge clk);
      total++;
      if (dbg_state !== S_EXEC || (chk_alu && (alu_a_sel !== ea || alu_b_sel !== eb))) begin
        bad++;
        $display("FAIL %s_exec: state=%0d a_sel=%b b_sel=%b want state=%0d a_sel=%b b_sel=%b",
                 name, dbg_state, alu_a_sel, alu_b_sel, S_EXEC, ea, eb);
      end
      cyc++;
      tick();
      branch_taken = !taken;
    end

    if (ls) begin
      for (int k = 0; k <= gdm; k++) begin
        mem_gnt = (k == gdm);
        @(negedge clk);
        total++;
        if (dbg_state !== S_MEM || mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_we !== st) begin
          bad++;
          $display("FAIL %s_mem: state=%0d req=%b addr_sel=%b we=%b want state=%0d req=1 addr_sel=1 we=%b",
                   name, dbg_state, mem_req, mem_addr_sel, mem_we, S_MEM, st);
        end
        cyc++;
        tick();
      end
      mem_gnt = 1'b0;
      if (ld) begin
        for (int k = 0; k <= rdm; k++) begin
          mem_rvalid = (k == rdm);
          @(negedge clk);
          total++;
          if (dbg_state !== S_MWAIT || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_mwait: state=%0d req=%b want state=%0d req=0",
                     name, dbg_state, mem_req, S_MWAIT);
          end
          cyc++;
          tick();
        end
        mem_rvalid = 1'b0;
      end
    end

    @(negedge clk);
    total++;
    if (dbg_state !== S_WB || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL %s_wb: state=%0d req=%b want state=%0d req=0", name, dbg_state, mem_req, S_WB);
    end
    cyc++;
    tick();
    branch_taken = 1'b0;

    total++;
    if (exp_q.size() != 0 || cyc != exp_cyc || dbg_state !== S_FETCH) begin
      bad++;
      $display("FAIL %s_done: pending=%0d cycles=%0d state=%0d want pending=0 cycles=%0d state=%0d",
               name, exp_q.size(), cyc, dbg_state, exp_cyc, S_FETCH);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; branch_taken = 1'b1;
    ir_opcode = OPC_JAL; ir_lo = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we,
         wb_sel, halted, halt_cause, retire} !== 16'd0 || dbg_state !== S_RESET) begin
      bad++;
      $display("FAIL reset_outputs: state=%0d req=%b ir_we=%b halted=%b want state=0 all outputs 0",
               dbg_state, mem_req, ir_we, halted);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state === S_FETCH) break;
      n++;
    end
    total++;
    if (n != RESET_PC_HOLD || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold: reset cycles=%0d req=%b want %0d req=1", n, mem_req, RESET_PC_HOLD);
    end
    tick();
  endtask

  task automatic test_addi();
    run_instr(OPC_OPIMM, 2'b11, 1'b0, 1, 1, 0, 0, "addi_late");
    run_instr(OPC_OPIMM, 2'b11, 1'b0, 0, 0, 0, 0, "addi_zero");
  endtask

  task automatic test_load();
    run_instr(OPC_LOAD, 2'b11, 1'b0, 0, 0, 3, 1, "lw_gnt3");
  endtask

  task automatic test_store_branch();
    run_instr(OPC_STORE,  2'b11, 1'b0, 0, 1, 1, 0, "sw");
    run_instr(OPC_BRANCH, 2'b11, 1'b1, 0, 0, 0, 0, "beq_taken");
    run_instr(OPC_BRANCH, 2'b11, 1'b0, 0, 0, 0, 0, "beq_not");
  endtask

  task automatic test_jal_lui();
    run_instr(OPC_JAL,   2'b11, 1'b0, 0, 0, 0, 0, "jal");
    run_instr(OPC_LUI,   2'b11, 1'b1, 0, 0, 0, 0, "lui");
    run_instr(OPC_JALR,  2'b11, 1'b0, 0, 0, 0, 0, "jalr");
    run_instr(OPC_AUIPC, 2'b11, 1'b0, 0, 0, 0, 0, "auipc");
    run_instr(OPC_OP,    2'b11, 1'b1, 0, 0, 0, 0, "op");
    run_instr(OPC_MISC,  2'b11, 1'b0, 0, 0, 0, 0, "fence");
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    for (int i = 0; i < 16; i++) begin
      op = legal_ops[$urandom_range(0, 9)];
      run_instr(op, 2'b11, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4), "b2b");
    end
  endtask

  task automatic test_illegal();
    reset_dut();
    run_instr(5'b11111, 2'b11, 1'b0, 0, 0, 0, 0, "ill_opc");
    reset_dut();
    run_instr(OPC_OPIMM, 2'b01, 1'b0, 1, 0, 0, 0, "ill_lo");
    reset_dut();
    total++;
    if (halted !== 1'b0 || halt_cause !== 2'd0 || dbg_state !== S_FETCH) begin
      bad++;
      $display("FAIL ill_reset_clear: halted=%b cause=%0d state=%0d want 0 0 %0d",
               halted, halt_cause, dbg_state, S_FETCH);
    end
    run_instr(OPC_OPIMM, 2'b11, 1'b0, 0, 0, 0, 0, "after_ill");
  endtask

  task automatic test_timeout();
    int n;
    reset_dut();
    mem_gnt = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (halted === 1'b1) break;
      if (dbg_state === S_FETCH && mem_req === 1'b1) n++;
    end
    total++;
    if (n != BUS_TIMEOUT || halted !== 1'b1 || halt_cause !== 2'd2 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_fetch: fetch cycles=%0d halted=%b cause=%0d req=%b want %0d 1 2 0",
               n, halted, halt_cause, mem_req, BUS_TIMEOUT);
    end
    tick();
  endtask

  task automatic test_reset_mid_mem();
    int n;
    reset_dut();
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; ir_opcode = OPC_LOAD; ir_lo = 2'b11; tick(); mem_rvalid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (dbg_state !== S_MEM || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL midmem_pre: state=%0d req=%b want state=%0d req=1", dbg_state, mem_req, S_MEM);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || dbg_state !== S_RESET) begin
      bad++;
      $display("FAIL midmem_abort: state=%0d req=%b want state=0 req=0", dbg_state, mem_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state === S_FETCH) break;
      total++;
      if (mem_req !== 1'b0) begin
        bad++;
        $display("FAIL midmem_reset_req: req=%b want 0", mem_req);
      end
      n++;
    end
    total++;
    if (n != RESET_PC_HOLD || mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
      bad++;
      $display("FAIL midmem_refetch: reset cycles=%0d req=%b addr_sel=%b want %0d 1 0",
               n, mem_req, mem_addr_sel, RESET_PC_HOLD);
    end
    tick();
    run_instr(OPC_OP, 2'b11, 1'b0, 0, 0, 0, 0, "after_midmem");
  endtask

  initial begin
    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; branch_taken = 1'b0;
    ir_opcode = 5'd0; ir_lo = 2'b11;
    test_reset();
    test_addi();
    test_load();
    test_store_branch();
    test_jal_lui();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: sim time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
